mem_bus_ctrl: RTL and testbench

Memory bus controller that sits directly downstream of the CPU bus port (addr / rd_req / rd_ack / rd_data / wr_data / wr_enable). It services CPU byte reads, including back-to-back word-read pairs, and posted CPU writes. It also services a second read master (video fetch) and arbitrates both onto one synchronous single-port memory with configurable read latency.

---
 rtl/mem_bus_ctrl_if.sv | 52 +++++
 rtl/mem_bus_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl_if
// Description : Bundles the CPU, video and memory-side bus signals of the
//               memory bus controller. The slave modport is the controller's
//               view. The master modport is the view of the surrounding
//               system (CPU, video fetch and memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 16
);
  // CPU port
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rd_req;
  logic              cpu_rd_ack;
  logic [7:0]        cpu_rd_data;
  logic [7:0]        cpu_wr_data;
  logic              cpu_wr_enable;
  logic              cpu_wr_pending;
  logic              wr_overrun;
  // Video fetch port
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_rd_req;
  logic              vid_rd_ack;
  logic [7:0]        vid_rd_data;
  // Memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;

  modport slave (
    input  cpu_addr, cpu_rd_req, cpu_wr_data, cpu_wr_enable,
    input  vid_addr, vid_rd_req,
    input  mem_rd_data,
    output cpu_rd_ack, cpu_rd_data, cpu_wr_pending, wr_overrun,
    output vid_rd_ack, vid_rd_data,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

  modport master (
    output cpu_addr, cpu_rd_req, cpu_wr_data, cpu_wr_enable,
    output vid_addr, vid_rd_req,
    output mem_rd_data,
    input  cpu_rd_ack, cpu_rd_data, cpu_wr_pending, wr_overrun,
    input  vid_rd_ack, vid_rd_data,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Arbitrates CPU byte reads, posted CPU writes (one-entry
//               buffer) and video-fetch reads onto one synchronous
//               single-port memory with MEM_LATENCY read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 16
) (
  input wire            clk,
  input wire            reset,
  mem_bus_ctrl_if.slave bus
);

  localparam logic [2:0] c_LAT = 3'(MEM_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_ACK   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t            r_state;
  logic [2:0]        r_lat_cnt;
  logic              r_grant_vid;   // master owning the current read
  logic              r_last_vid;    // master granted most recently

  logic              r_wbuf_valid;
  logic [ADDR_W-1:0] r_wbuf_addr;
  logic [7:0]        r_wbuf_data;
  logic              r_overrun;

  logic              r_cpu_rd_ack;
  logic [7:0]        r_cpu_rd_data;
  logic              r_vid_rd_ack;
  logic [7:0]        r_vid_rd_data;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd_en;
  logic              r_mem_wr_en;
  logic [7:0]        r_mem_wr_data;

  logic              w_drain;
  logic              w_any_req;
  logic              w_pick_vid;

  // The buffered write leaves the buffer on the edge that exits WRITE.
  assign w_drain    = (r_state == S_WRITE);
  assign w_any_req  = bus.cpu_rd_req | bus.vid_rd_req;
  // Lone requester wins; under contention the master not granted last wins.
  assign w_pick_vid = bus.vid_rd_req & (~bus.cpu_rd_req | ~r_last_vid);

  // Posted-write buffer: accepts a strobe when empty or draining this edge,
  // otherwise drops it and flags a sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wbuf_valid <= 1'b0;
      r_wbuf_addr  <= '0;
      r_wbuf_data  <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (bus.cpu_wr_enable && (!r_wbuf_valid || w_drain)) begin
        r_wbuf_valid <= 1'b1;
        r_wbuf_addr  <= bus.cpu_addr;
        r_wbuf_data  <= bus.cpu_wr_data;
      end else if (w_drain) begin
        r_wbuf_valid <= 1'b0;
      end
      if (bus.cpu_wr_enable && r_wbuf_valid && !w_drain) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Access sequencer: write-first arbitration, fixed-latency read capture,
  // and a one-cycle hold after each ack so masters can update requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_lat_cnt     <= '0;
      r_grant_vid   <= 1'b0;
      r_last_vid    <= 1'b1;
      r_cpu_rd_ack  <= 1'b0;
      r_cpu_rd_data <= '0;
      r_vid_rd_ack  <= 1'b0;
      r_vid_rd_data <= '0;
      r_mem_addr    <= '0;
      r_mem_rd_en   <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_data <= '0;
    end else begin
      r_cpu_rd_ack <= 1'b0;
      r_vid_rd_ack <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      r_mem_wr_en  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_wbuf_valid) begin
            r_mem_addr    <= r_wbuf_addr;
            r_mem_wr_data <= r_wbuf_data;
            r_mem_wr_en   <= 1'b1;
            r_state       <= S_WRITE;
          end else if (w_any_req) begin
            r_mem_addr  <= w_pick_vid ? bus.vid_addr : bus.cpu_addr;
            r_mem_rd_en <= 1'b1;
            r_grant_vid <= w_pick_vid;
            r_last_vid  <= w_pick_vid;
            r_lat_cnt   <= c_LAT;
            r_state     <= S_READ;
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
        end
        S_READ: begin
          // Counter loaded with the latency at grant; data is valid on the
          // edge that finds it already at zero.
          if (r_lat_cnt == 3'd0) begin
            if (r_grant_vid) begin
              r_vid_rd_data <= bus.mem_rd_data;
              r_vid_rd_ack  <= 1'b1;
            end else begin
              r_cpu_rd_data <= bus.mem_rd_data;
              r_cpu_rd_ack  <= 1'b1;
            end
            r_state <= S_ACK;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        S_ACK: begin
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rd_ack     = r_cpu_rd_ack;
  assign bus.cpu_rd_data    = r_cpu_rd_data;
  assign bus.cpu_wr_pending = r_wbuf_valid;
  assign bus.wr_overrun     = r_overrun;
  assign bus.vid_rd_ack     = r_vid_rd_ack;
  assign bus.vid_rd_data    = r_vid_rd_data;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_rd_en      = r_mem_rd_en;
  assign bus.mem_wr_en      = r_mem_wr_en;
  assign bus.mem_wr_data    = r_mem_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Directed self-checking bench for mem_bus_ctrl. One instance
//               runs with MEM_LATENCY=1 and a second with MEM_LATENCY=3
//               for the asynchronous-reset scenario. Both share one memory
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

  logic clk;
  logic reset;
  logic reset3;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt   = 0;
  int ack3_cnt = 0;

  mem_bus_ctrl_if #(.ADDR_W(16)) b  ();
  mem_bus_ctrl_if #(.ADDR_W(16)) b3 ();

  mem_bus_ctrl #(.MEM_LATENCY(1), .ADDR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  mem_bus_ctrl #(.MEM_LATENCY(3), .ADDR_W(16)) dut3 (
    .clk   (clk),
    .reset (reset3),
    .bus   (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared memory: preload port, write port from dut, read pipelines.
  logic [7:0]  mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  p1;
  logic [7:0]  q1, q2, q3;

  // Memory writes and latency-1 read pipe; junk data when not strobed.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (b.mem_wr_en) mem[b.mem_addr] <= b.mem_wr_data;
    p1 <= b.mem_rd_en ? mem[b.mem_addr] : 8'hEE;
  end
  assign b.mem_rd_data = p1;

  // Latency-3 read pipe for the second instance.
  always @(posedge clk) begin
    q1 <= b3.mem_rd_en ? mem[b3.mem_addr] : 8'hEE;
    q2 <= q1;
    q3 <= q2;
  end
  assign b3.mem_rd_data = q3;

  // Event counters.
  always @(posedge clk) begin
    if (b.mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (b3.cpu_rd_ack) ack3_cnt <= ack3_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic wait_ack(input bit vid, input int maxc, output int cyc);
    cyc = 0;
    while (((vid ? b.vid_rd_ack : b.cpu_rd_ack) !== 1'b1) && cyc < maxc) begin
      tick();
      cyc++;
    end
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    int cyc;
    b.cpu_addr = a; b.cpu_rd_req = 1'b1;
    wait_ack(1'b0, 20, cyc);
    check({tag, "_ack"}, b.cpu_rd_ack, 1);
    check({tag, "_data"}, b.cpu_rd_data, exp);
    b.cpu_rd_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int base;
    int a0;
    bit exp_vid;
    logic [7:0] exp_cd, exp_vd;

    reset = 1'b1; reset3 = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    b.cpu_addr = '0; b.cpu_rd_req = 1'b0; b.cpu_wr_data = '0; b.cpu_wr_enable = 1'b0;
    b.vid_addr = '0; b.vid_rd_req = 1'b0;
    b3.cpu_addr = '0; b3.cpu_rd_req = 1'b0; b3.cpu_wr_data = '0; b3.cpu_wr_enable = 1'b0;
    b3.vid_addr = '0; b3.vid_rd_req = 1'b0;

    preload(16'h0444, 8'hA9);
    preload(16'h0445, 8'h00);
    preload(16'h0446, 8'h10);
    preload(16'h0100, 8'h11);
    preload(16'h0200, 8'h22);
    preload(16'h0300, 8'h33);
    preload(16'h2000, 8'hC3);
    preload(16'h2100, 8'hD1);
    preload(16'h2200, 8'h44);
    preload(16'h2300, 8'h55);

    // Reset state
    check("rst_acks",    {b.cpu_rd_ack, b.vid_rd_ack, b.mem_rd_en, b.mem_wr_en}, 0);
    check("rst_wflags",  {b.cpu_wr_pending, b.wr_overrun}, 0);
    check("rst_rd_data", {b.cpu_rd_data, b.vid_rd_data}, 0);
    check("rst_mem",     {b.mem_addr, b.mem_wr_data}, 0);
    reset = 1'b0; reset3 = 1'b0;
    tick();

    // CPU single read, latency 1
    base = rd_cnt;
    b.cpu_addr = 16'h0444; b.cpu_rd_req = 1'b1;
    tick();
    check("rd1_rd_en", b.mem_rd_en, 1);
    check("rd1_addr",  b.mem_addr, 16'h0444);
    check("rd1_ack_early", b.cpu_rd_ack, 0);
    b.cpu_addr = 16'h0100;  // must not affect the access in flight
    tick();
    check("rd1_rd_en_low", b.mem_rd_en, 0);
    check("rd1_ack_early2", b.cpu_rd_ack, 0);
    tick();
    check("rd1_ack",  b.cpu_rd_ack, 1);
    check("rd1_data", b.cpu_rd_data, 8'hA9);
    b.cpu_rd_req = 1'b0;
    tick();
    check("rd1_ack_pulse", b.cpu_rd_ack, 0);
    check("rd1_data_hold", b.cpu_rd_data, 8'hA9);
    tick();
    check("rd1_one_read", rd_cnt - base, 1);

    // CPU word read: address switched on the first ack
    base = rd_cnt;
    b.cpu_addr = 16'h0445; b.cpu_rd_req = 1'b1;
    wait_ack(1'b0, 20, cyc);
    check("wd_lat_lo",  cyc, 3);
    check("wd_data_lo", b.cpu_rd_data, 8'h00);
    b.cpu_addr = 16'h0446;
    tick();
    wait_ack(1'b0, 20, cyc);
    check("wd_lat_hi",  cyc, 4);
    check("wd_data_hi", b.cpu_rd_data, 8'h10);
    b.cpu_rd_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("wd_two_reads", rd_cnt - base, 2);

    // Contention from reset: CPU, VID, CPU, VID
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b.cpu_addr = 16'h0100; b.vid_addr = 16'h0200;
    b.cpu_rd_req = 1'b1; b.vid_rd_req = 1'b1;
    exp_cd = 8'h00; exp_vd = 8'h00;
    for (int g = 0; g < 4; g++) begin
      cyc = 0;
      while (!(b.cpu_rd_ack || b.vid_rd_ack) && cyc < 20) begin
        tick();
        cyc++;
      end
      exp_vid = (g % 2) == 1;
      if (exp_vid) exp_vd = 8'h22; else exp_cd = 8'h11;
      check("cont_vid_ack", b.vid_rd_ack, exp_vid);
      check("cont_cpu_ack", b.cpu_rd_ack, !exp_vid);
      check("cont_cpu_data", b.cpu_rd_data, exp_cd);
      check("cont_vid_data", b.vid_rd_data, exp_vd);
      tick();
    end
    b.cpu_rd_req = 1'b0; b.vid_rd_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Posted write during a video read, ahead of a waiting CPU read
    b.vid_addr = 16'h0300; b.vid_rd_req = 1'b1;
    tick();
    check("pw_vid_grant", b.mem_addr, 16'h0300);
    b.cpu_addr = 16'h2000; b.cpu_wr_data = 8'h5A; b.cpu_wr_enable = 1'b1;
    b.cpu_rd_req = 1'b1;
    tick();
    b.cpu_wr_enable = 1'b0;
    check("pw_pending", b.cpu_wr_pending, 1);
    tick();
    check("pw_vid_ack",  b.vid_rd_ack, 1);
    check("pw_vid_data", b.vid_rd_data, 8'h33);
    b.vid_rd_req = 1'b0;
    tick(); tick(); tick();
    check("pw_wr_en",   b.mem_wr_en, 1);
    check("pw_rd_en",   b.mem_rd_en, 0);
    check("pw_wr_addr", b.mem_addr, 16'h2000);
    check("pw_wr_data", b.mem_wr_data, 8'h5A);
    tick();
    check("pw_drained", {b.cpu_wr_pending, b.mem_wr_en}, 0);
    wait_ack(1'b0, 20, cyc);
    check("pw_rd_lat",  cyc, 3);
    check("pw_rd_data", b.cpu_rd_data, 8'h5A);
    b.cpu_rd_req = 1'b0;
    tick(); tick();

    // Overrun: strobes while the buffer is full
    b.vid_addr = 16'h0300; b.vid_rd_req = 1'b1;
    tick();
    b.cpu_addr = 16'h2100; b.cpu_wr_data = 8'h77; b.cpu_wr_enable = 1'b1;
    tick();
    check("ov_pending", b.cpu_wr_pending, 1);
    check("ov_clear_before", b.wr_overrun, 0);
    b.cpu_addr = 16'h2200; b.cpu_wr_data = 8'h88;
    tick();
    check("ov_set", b.wr_overrun, 1);
    check("ov_vid_ack", b.vid_rd_ack, 1);
    b.vid_rd_req = 1'b0;
    b.cpu_addr = 16'h2300; b.cpu_wr_data = 8'h99;
    tick();
    b.cpu_wr_enable = 1'b0;
    tick(); tick();
    check("ov_wr_en",   b.mem_wr_en, 1);
    check("ov_wr_addr", b.mem_addr, 16'h2100);
    check("ov_wr_data", b.mem_wr_data, 8'h77);
    tick();
    check("ov_sticky",  {b.wr_overrun, b.cpu_wr_pending}, 2'b10);
    cpu_read("ov_rd_first", 16'h2100, 8'h77);
    cpu_read("ov_rd_drop2", 16'h2200, 8'h44);
    cpu_read("ov_rd_drop3", 16'h2300, 8'h55);
    check("ov_sticky_end", b.wr_overrun, 1);

    // Asynchronous reset in READ, latency 3
    a0 = ack3_cnt;
    b3.cpu_addr = 16'h0444; b3.cpu_rd_req = 1'b1;
    tick();
    check("ar_rd_en", b3.mem_rd_en, 1);
    check("ar_addr",  b3.mem_addr, 16'h0444);
    tick();
    #2 reset3 = 1'b1;
    #1;
    check("ar_addr_zero", b3.mem_addr, 0);
    check("ar_outs_zero", {b3.cpu_rd_ack, b3.mem_rd_en, b3.cpu_rd_data}, 0);
    b3.cpu_rd_req = 1'b0;
    tick(); tick(); tick(); tick();
    check("ar_no_ack", ack3_cnt - a0, 0);
    reset3 = 1'b0;
    tick();
    b3.cpu_addr = 16'h0446; b3.cpu_rd_req = 1'b1;
    cyc = 0;
    while (b3.cpu_rd_ack !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("ar_fresh_lat",  cyc, 5);
    check("ar_fresh_data", b3.cpu_rd_data, 8'h10);
    b3.cpu_rd_req = 1'b0;
    tick(); tick();
    check("ar_one_ack", ack3_cnt - a0, 1);
    check("ar_no_wr", b3.mem_wr_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
